// File: rtl/ins_fetch.sv
// Instruction fetch unit.
// Issues one read per new instruction address, captures the returned word
// into the instruction register, and gives up on a fetch that is not
// acknowledged within TIMEOUT wait cycles. A timed-out fetch raises a sticky
// error flag, and the fetch is retried while start stays high.
module ins_fetch #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        ins_addr,
    output logic              mem_rd,
    output logic [7:0]        mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic              fetch_done,
    output logic              busy,
    output logic              err_timeout
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Value of the wait timer in the final wait cycle before abort.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t              state_r;
    state_t              state_s;
    logic                mem_rd_r;
    logic                mem_rd_s;
    logic [7:0]          mem_addr_r;
    logic [7:0]          mem_addr_s;
    logic [DATA_W-1:0]   ir_r;
    logic [DATA_W-1:0]   ir_s;
    logic                fetch_done_r;
    logic                fetch_done_s;
    logic                err_timeout_r;
    logic                err_timeout_s;
    logic                have_word_r;
    logic                have_word_s;
    logic [7:0]          last_addr_r;
    logic [7:0]          last_addr_s;
    logic [7:0]          timer_r;
    logic [7:0]          timer_s;
    logic                need_s;
    logic                busy_s;

    // A fetch is needed when enabled and the held word is absent or stale.
    assign need_s = start && (!have_word_r || (ins_addr != last_addr_r));
    assign busy_s = (state_r == ST_WAIT);

    // Next-state and next-register decode; every register holds by default.
    always_comb begin
        state_s       = state_r;
        mem_rd_s      = mem_rd_r;
        mem_addr_s    = mem_addr_r;
        ir_s          = ir_r;
        fetch_done_s  = 1'b0;
        err_timeout_s = err_timeout_r;
        have_word_s   = have_word_r;
        last_addr_s   = last_addr_r;
        timer_s       = timer_r;
        case (state_r)
            ST_IDLE: begin
                if (need_s) begin
                    state_s    = ST_WAIT;
                    mem_rd_s   = 1'b1;
                    mem_addr_s = ins_addr;
                    timer_s    = 8'd0;
                end else begin
                    mem_rd_s   = 1'b0;
                end
            end
            ST_WAIT: begin
                // The acknowledge wins over a timeout that expires in the same cycle.
                if (mem_ack && mem_rd_r) begin
                    state_s      = ST_IDLE;
                    mem_rd_s     = 1'b0;
                    ir_s         = mem_rdata;
                    last_addr_s  = mem_addr_r;
                    have_word_s  = 1'b1;
                    fetch_done_s = 1'b1;
                end else if (timer_r == TIMER_LAST) begin
                    state_s       = ST_IDLE;
                    mem_rd_s      = 1'b0;
                    err_timeout_s = 1'b1;
                end else begin
                    timer_s = timer_r + 8'd1;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                mem_rd_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            mem_rd_r      <= 1'b0;
            mem_addr_r    <= 8'd0;
            ir_r          <= {DATA_W{1'b0}};
            fetch_done_r  <= 1'b0;
            err_timeout_r <= 1'b0;
            have_word_r   <= 1'b0;
            last_addr_r   <= 8'd0;
            timer_r       <= 8'd0;
        end else begin
            state_r       <= state_s;
            mem_rd_r      <= mem_rd_s;
            mem_addr_r    <= mem_addr_s;
            ir_r          <= ir_s;
            fetch_done_r  <= fetch_done_s;
            err_timeout_r <= err_timeout_s;
            have_word_r   <= have_word_s;
            last_addr_r   <= last_addr_s;
            timer_r       <= timer_s;
        end
    end

    assign mem_rd      = mem_rd_r;
    assign mem_addr    = mem_addr_r;
    assign ir          = ir_r;
    assign fetch_done  = fetch_done_r;
    assign err_timeout = err_timeout_r;
    assign busy        = busy_s;
    // The word is only trusted when it matches the current address and no fetch is in flight.
    assign ir_valid    = have_word_r && (last_addr_r == ins_addr) && !busy_s;

endmodule

// File: doc/ins_fetch.md
INS_FETCH -- requirements
Module: ins_fetch

Interface
REQ-001 Parameter DATA_W, default 16, instruction word width in bits.
REQ-002 Parameter TIMEOUT, default 15, maximum WAIT cycles without mem_ack before abort; legal range 1..255.
REQ-003 clk  input  1  system clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  fetch enable; no new fetch begins while low.
REQ-006 ins_addr  input  8  instruction address from the program counter.
REQ-007 mem_rd  output  1  read request to instruction memory.
REQ-008 mem_addr  output  8  read address, held stable while mem_rd is high.
REQ-009 mem_ack  input  1  memory response strobe; mem_rdata valid in the same cycle.
REQ-010 mem_rdata  input  DATA_W  read data.
REQ-011 ir  output  DATA_W  instruction register.
REQ-012 ir_valid  output  1  ir holds the word for the current ins_addr.
REQ-013 fetch_done  output  1  one-cycle pulse when ir is updated.
REQ-014 busy  output  1  high while in WAIT.
REQ-015 err_timeout  output  1  sticky flag: a fetch was aborted by timeout.

Function
REQ-016 The FSM shall have exactly two states, IDLE and WAIT; busy shall equal (state==WAIT).
REQ-017 The block shall keep an internal last_addr[7:0] and a have_word flag.
REQ-018 need shall equal start && (!have_word || ins_addr != last_addr).
REQ-019 In IDLE with need high, the next edge shall move to WAIT, set mem_rd=1, mem_addr=ins_addr, and clear the wait timer.
REQ-020 In IDLE with need low, state, mem_rd (0) and ir shall hold.
REQ-021 mem_ack shall be sampled only in WAIT with mem_rd high; mem_ack in IDLE shall be ignored with no effect.
REQ-022 In WAIT with mem_ack high, the next edge shall set ir=mem_rdata, last_addr=mem_addr, have_word=1, and mem_rd=0, pulse fetch_done for exactly one cycle, and return to IDLE.
REQ-023 Minimum latency: with mem_ack high in the first WAIT cycle, ir shall update 2 edges after need is seen in IDLE.
REQ-024 In WAIT without mem_ack, the timer shall increment by 1 each cycle.
REQ-025 When the timer reaches TIMEOUT-1 without ack, the next edge shall set err_timeout=1 and mem_rd=0 and return to IDLE, leaving ir, last_addr and have_word unchanged.
REQ-026 If mem_ack arrives in the same cycle the timer reaches TIMEOUT-1, ack shall win and no error shall be flagged.
REQ-027 A change of ins_addr during WAIT shall not alter mem_addr; the current fetch completes, then need re-evaluates in IDLE and triggers a refetch.
REQ-028 start falling during WAIT shall not abort the current fetch.
REQ-029 ir_valid shall equal have_word && (last_addr == ins_addr) && !busy, decoded combinationally.
REQ-030 err_timeout shall clear only on reset.
REQ-031 After a timeout, need remains high, so a retry shall start on the next IDLE cycle if start is high.
REQ-032 mem_addr shall hold its last value when mem_rd is low.

Reset
REQ-033 reset, sampled at posedge clk, shall have priority over all other inputs.
REQ-034 On reset: state=IDLE, mem_rd=0, mem_addr=0, ir=0, ir_valid=0, fetch_done=0, busy=0, err_timeout=0, have_word=0, last_addr=0, timer=0.
REQ-035 Reset asserted during WAIT shall drop mem_rd at that edge and discard any mem_ack in the same cycle.

Verification
REQ-036 start=1, ins_addr=0x00; mem_ack=1 with rdata=0x1234 in the first WAIT cycle -> mem_rd for 1 cycle, ir=0x1234 and fetch_done pulse 2 edges after start, then ir_valid=1.
REQ-037 ins_addr steps 0x00->0x01 with ack delayed 3 cycles -> mem_addr=0x01, busy for 4 cycles, ir_valid=0 until ir updates, one fetch_done pulse.
REQ-038 TIMEOUT=15, no ack -> mem_rd high for exactly 15 cycles, then err_timeout=1, ir unchanged, and a retry begins the next cycle.
REQ-039 ins_addr changes 0x05->0x06 mid-WAIT -> mem_addr stays 0x05; on ack ir_valid=0; an automatic refetch of 0x06 follows.
REQ-040 reset pulsed during WAIT with mem_ack=1 in the same cycle -> all outputs at reset values, ir=0, no fetch_done.
REQ-041 start=0, ins_addr toggling, spurious mem_ack -> mem_rd stays 0, ir stays unchanged.
